axis_frame_tx: RTL
==================

# axis_frame_tx

- Streams one stored grayscale frame out as AXI-Stream: it reads pixels from a synchronous-read frame RAM in raster order and emits them with start-of-frame on `m_axis_tuser` and end-of-line on `m_axis_tlast`.
- It is the transmit end of the pixel-stream interface that the kernel pipeline consumes, used both to feed the filters from memory and as the bench/system frame source.
- It sustains 1 pixel/cycle under full backpressure compliance.

## Interface
- `IMG_W`, default 670, pixels per line.
- `IMG_H`, default 410, lines per frame.
- `AXIS_TDATA_WIDTH`, default 8, pixel width.
- `AXIS_TUSER_WIDTH`, default 1, tuser width; bit 0 carries SOF, other bits are 0.
- `ADDR_W`, default `$clog2(IMG_W*IMG_H)` (19), RAM address width.
- `aclk`, in, 1, sole clock; all logic is rising-edge.
- `aresetn`, in, 1, asynchronous active-low reset.
- `start`, in, 1, single-cycle frame request; ignored while `busy`.
- `busy`, out, 1, high from the cycle after `start` is accepted until `done`.
- `done`, out, 1, one-cycle pulse after the last pixel handshake.
- `mem_rd_en`, out, 1, RAM read strobe.
- `mem_rd_addr`, out, ADDR_W, linear pixel address `row*IMG_W+col`.
- `mem_rd_data`, in, AXIS_TDATA_WIDTH, RAM data, valid exactly 1 cycle after `mem_rd_en`.
- `m_axis_tdata`, out, AXIS_TDATA_WIDTH, pixel.
- `m_axis_tvalid`, out, 1, beat valid.
- `m_axis_tready`, in, 1, sink ready.
- `m_axis_tuser`, out, AXIS_TUSER_WIDTH, bit 0 high on pixel (0,0) only.
- `m_axis_tlast`, out, 1, high on `col == IMG_W-1`.

## Operation
- FSM `tx_state_t`:
  - **TX_IDLE**: `start` -> TX_RUN; reset issue counters to row 0, col 0.
  - **TX_RUN**: issue reads. After issuing address `IMG_W*IMG_H-1` -> TX_DRAIN.
  - **TX_DRAIN**: wait for the in-flight read and the FIFO to empty. When the final handshake completes -> TX_IDLE; `done` fires on the next cycle.
- Issue side:
  - `col`/`row` counters; `col` wraps at `IMG_W-1` and increments `row`.
  - SOF and EOL flags are computed at issue time and delayed 1 cycle alongside the read, so they are written into the FIFO with the data.
- Output buffer: 2-entry FIFO holding {tdata, tuser, tlast}. The head drives the `m_axis_*` outputs and `tvalid = !empty`.
- Issue rule:
  - `mem_rd_en = (state==TX_RUN) && (fifo_count + inflight - pop) < 2`, where `pop = tvalid && tready` and `inflight` is the registered `mem_rd_en`.
  - The FIFO therefore never overflows and the RAM is never read speculatively.
- AXIS rules:
  - Once `tvalid` is high, tdata/tuser/tlast are held stable until `tready`.
  - `tvalid` never depends combinationally on `tready`.
- `start` in TX_RUN/TX_DRAIN is dropped, not queued. `start` in the same cycle as `done` is accepted (state is TX_IDLE).
- Reset mid-frame: all state clears asynchronously and `tvalid` drops at once. The next `start` restarts at address 0 with SOF.
- `mem_rd_addr` holds its last value when `mem_rd_en` is low.

## Timing
- Reset values:
  - `busy`, `done`, `mem_rd_en`, `m_axis_tvalid`, `m_axis_tuser`, `m_axis_tlast` = 0.
  - `mem_rd_addr` and `m_axis_tdata` = 0.
  - state = TX_IDLE, FIFO empty.
- `start` sampled at edge k:
  - `busy` and `mem_rd_en` (addr 0) are high after edge k.
  - Data is captured at edge k+2, so the first `tvalid` is high after edge k+2 (latency 2).
- With `tready` held high: one beat per cycle, no bubbles. The frame occupies `IMG_W*IMG_H` consecutive cycles.
- Last beat accepted at edge n: `done` is high for the cycle after edge n, and `busy` is low in that same cycle.
- A `tready` low for N cycles stalls output by exactly N cycles and loses no pixel.

## Structure
- Package additions in `img_processing_pkg`:
  - `tx_state_t` enum {TX_IDLE, TX_RUN, TX_DRAIN}.
  - `localparam FRAME_PIXELS = IMG_W*IMG_H`.
  - `FRAME_ADDR_W`.
- Sub-module `axis_fifo2`: 2-entry register FIFO with push, pop, count, and a head output. It is reused by other stream stages.
- Top: `axis_frame_tx` = FSM + issue counters + flag delay + `axis_fifo2`.

## Test plan
Run with IMG_W=4, IMG_H=3 and RAM content `mem[a]=a`.
- **Full rate**: `start` pulse with `tready=1`.
  - Expect 12 beats on consecutive cycles, data 0..11.
  - `tuser` only on data 0; `tlast` on 3, 7, 11.
  - First `tvalid` 2 cycles after `start`; `done` 1 cycle after beat 11.
- **Backpressure**: `tready` toggles 1,0,0,1 repeating.
  - Expect 12 beats in order, each beat's data/flags stable while stalled.
  - `mem_rd_en` never leaves more than 2 entries buffered.
- **Start while busy**: second `start` at beat 5 -> ignored; exactly 12 beats and one `done`.
- **Back-to-back**: `start` in the `done` cycle -> second frame begins with data 0 and `tuser=1`, 24 beats total.
- **Reset mid-frame**: `aresetn` low at beat 6.
  - All outputs go to 0 immediately.
  - After release plus `start`, the frame restarts at data 0 with SOF.
- **Long stall at end**: `tready=0` from beat 11 for 20 cycles -> `busy` stays high, no extra reads; `done` fires 1 cycle after the beat-11 handshake.

Source files
------------

// File: rtl/img_processing_pkg.sv
// Shared image-pipeline types and default frame geometry.
package img_processing_pkg;

  localparam int IMG_W_DEF    = 670;
  localparam int IMG_H_DEF    = 410;
  localparam int FRAME_PIXELS = IMG_W_DEF * IMG_H_DEF;
  localparam int FRAME_ADDR_W = $clog2(FRAME_PIXELS);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_RUN   = 2'd1,
    TX_DRAIN = 2'd2
  } tx_state_t;

  // Counter width that stays legal for a dimension of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_fifo2.sv
// Two-entry register FIFO; the head entry is always presented on head.
module axis_fifo2 #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count,
  output logic         empty
);

  logic [W-1:0] tail;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count != 2'd2) begin
            if (count == 2'd0) head <= din;
            else               tail <= din;
            count <= count + 2'd1;
          end
        end
        2'b01: begin
          if (count != 2'd0) begin
            head  <= tail;
            count <= count - 2'd1;
          end
        end
        2'b11: begin
          // Simultaneous push/pop keeps the count; an empty FIFO cannot pop.
          if (count == 2'd2) begin
            head <= tail;
            tail <= din;
          end else if (count == 2'd1) begin
            head <= din;
          end else begin
            head  <= din;
            count <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign empty = (count == 2'd0);

endmodule

// File: rtl/axis_frame_tx.sv
// Streams one stored frame from a synchronous-read RAM as AXI-Stream, raster order.
// state    | meaning
// TX_IDLE  | waiting for start; issue counters parked at pixel 0
// TX_RUN   | issuing RAM reads while the output buffer has room
// TX_DRAIN | all reads issued; emptying in-flight read and FIFO
module axis_frame_tx
  import img_processing_pkg::*;
#(
  parameter int IMG_W            = IMG_W_DEF,
  parameter int IMG_H            = IMG_H_DEF,
  parameter int AXIS_TDATA_WIDTH = 8,
  parameter int AXIS_TUSER_WIDTH = 1,
  parameter int ADDR_W           = $clog2(IMG_W * IMG_H)
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_rd_en,
  output logic [ADDR_W-1:0]           mem_rd_addr,
  input  logic [AXIS_TDATA_WIDTH-1:0] mem_rd_data,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                        m_axis_tlast
);

  localparam int PIXELS = IMG_W * IMG_H;
  localparam int COL_W  = cnt_width(IMG_W);
  localparam int ROW_W  = cnt_width(IMG_H);
  localparam int ENT_W  = AXIS_TDATA_WIDTH + 2;

  tx_state_t         state, state_nx;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr_cnt, addr_last;
  logic              inflight, sof_d, eol_d, done_r;
  logic              pop, rd_en, eol_now, last_issue, last_pop;
  logic [2:0]        occ_nx;
  logic [ENT_W-1:0]  fifo_head;
  logic [1:0]        fifo_count;
  logic              fifo_empty;

  assign pop        = !fifo_empty && m_axis_tready;
  // Entries still owed to the sink after this edge, before any new read.
  assign occ_nx     = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign rd_en      = (state == TX_RUN) && (occ_nx < 3'd2);
  assign eol_now    = (col == COL_W'(IMG_W - 1));
  assign last_issue = rd_en && (addr_cnt == ADDR_W'(PIXELS - 1));
  assign last_pop   = (state == TX_DRAIN) && pop && !inflight && (fifo_count == 2'd1);

  always_comb begin
    state_nx = state;
    unique case (state)
      TX_IDLE:  if (start)      state_nx = TX_RUN;
      TX_RUN:   if (last_issue) state_nx = TX_DRAIN;
      TX_DRAIN: if (last_pop)   state_nx = TX_IDLE;
      default:                  state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= TX_IDLE;
      col       <= '0;
      row       <= '0;
      addr_cnt  <= '0;
      addr_last <= '0;
      inflight  <= 1'b0;
      sof_d     <= 1'b0;
      eol_d     <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= rd_en;
      done_r   <= last_pop;
      if (state == TX_IDLE && start) begin
        col      <= '0;
        row      <= '0;
        addr_cnt <= '0;
      end else if (rd_en) begin
        addr_last <= addr_cnt;
        addr_cnt  <= addr_cnt + ADDR_W'(1);
        // Flags travel one cycle behind the address so they meet the read data.
        sof_d     <= (col == '0) && (row == '0);
        eol_d     <= eol_now;
        if (eol_now) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  axis_fifo2 #(.W(ENT_W)) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (inflight),
    .pop     (pop),
    .din     ({mem_rd_data, sof_d, eol_d}),
    .head    (fifo_head),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  always_comb begin
    m_axis_tuser    = '0;
    m_axis_tuser[0] = fifo_head[1];
  end

  assign m_axis_tdata  = fifo_head[ENT_W-1:2];
  assign m_axis_tlast  = fifo_head[0];
  assign m_axis_tvalid = !fifo_empty;
  assign mem_rd_en     = rd_en;
  assign mem_rd_addr   = rd_en ? addr_cnt : addr_last;
  assign busy          = (state != TX_IDLE);
  assign done          = done_r;

endmodule
